// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared tag and address types for the command-tracking CAM
package cam_pkg;

  localparam int CMD_ID_WIDTH  = 8;
  localparam int PROC_COUNT    = 4;
  localparam int PROC_ID_WIDTH = (PROC_COUNT > 1) ? $clog2(PROC_COUNT) : 1;
  localparam int CAM_DEPTH     = 8;

  typedef logic [CMD_ID_WIDTH-1:0]  cmd_id_t;
  typedef logic [PROC_ID_WIDTH-1:0] proc_id_t;

  typedef struct packed {
    cmd_id_t  cmd_id;
    proc_id_t proc_id;
  } tag_t;

  typedef logic [$clog2(CAM_DEPTH)-1:0] cam_addr_t;

  localparam int TAG_WIDTH = $bits(tag_t);

endpackage

// File: rtl/prio_enc.sv
// rtl/prio_enc.sv - lowest-set-bit priority encoder with any/multi flags
module prio_enc #(
  parameter int WIDTH = 8,
  localparam int IW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IW-1:0]    idx,
  output logic             any,
  output logic             multi
);

  // Scan high to low so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
    any   = |vec;
    multi = |(vec & (vec - WIDTH'(1)));
  end

endmodule

// File: rtl/mask_alloc_cam.sv
// rtl/mask_alloc_cam.sv - self-allocating tag CAM with masked multi-port lookup
module mask_alloc_cam
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH = TAG_WIDTH,
  parameter int DEPTH      = CAM_DEPTH,
  parameter int NUM_LK     = 2,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ins_valid,
  input  logic [DATA_WIDTH-1:0]        ins_data,
  output logic                         ins_ready,
  output logic [ADDR_WIDTH-1:0]        ins_addr,
  input  logic                         del_valid,
  input  logic [ADDR_WIDTH-1:0]        del_addr,
  input  logic                         flush,
  input  logic [NUM_LK-1:0]            lk_valid,
  input  logic [NUM_LK*DATA_WIDTH-1:0] lk_data,
  input  logic [NUM_LK*DATA_WIDTH-1:0] lk_mask,
  output logic [NUM_LK-1:0]            lk_rvalid,
  output logic [NUM_LK-1:0]            lk_hit,
  output logic [NUM_LK-1:0]            lk_multi,
  output logic [NUM_LK*ADDR_WIDTH-1:0] lk_addr,
  output logic [NUM_LK*DEPTH-1:0]      lk_vec,
  output logic [ADDR_WIDTH:0]          count,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0]      valid;
  logic [DEPTH-1:0]      valid_next;
  logic [CW-1:0]         count_next;
  logic                  ins_fire;
  logic                  free_any_unused;
  logic                  free_multi_unused;

  // Free-slot allocation looks only at pre-edge valid, so a slot freed this
  // cycle cannot be handed out until the next one.
  prio_enc #(.WIDTH(DEPTH)) u_free_enc (
    .vec   (~valid),
    .idx   (ins_addr),
    .any   (free_any_unused),
    .multi (free_multi_unused)
  );

  assign ins_ready = !full;
  assign ins_fire  = ins_valid && ins_ready;

  // Next valid vector: delete, then insert (insert wins on same slot), flush overrides all.
  always_comb begin
    valid_next = valid;
    if (del_valid) valid_next[del_addr] = 1'b0;
    if (ins_fire)  valid_next[ins_addr] = 1'b1;
    if (flush)     valid_next = '0;
    count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_next = count_next + CW'(valid_next[i]);
    end
  end

  // Valid bits and occupancy status, all derived from the same next-state vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      valid <= valid_next;
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Tag storage; contents of invalid slots are never observed, so no reset.
  always_ff @(posedge clk) begin
    if (ins_fire) data[ins_addr] <= ins_data;
  end

  for (genvar p = 0; p < NUM_LK; p++) begin : g_lk
    logic [DATA_WIDTH-1:0] key;
    logic [DATA_WIDTH-1:0] mask;
    logic [DEPTH-1:0]      match;
    logic [ADDR_WIDTH-1:0] m_idx;
    logic                  m_any;
    logic                  m_multi;

    assign key  = lk_data[p*DATA_WIDTH +: DATA_WIDTH];
    assign mask = lk_mask[p*DATA_WIDTH +: DATA_WIDTH];

    // Masked compare of every entry against this port's key.
    always_comb begin
      match = '0;
      for (int i = 0; i < DEPTH; i++) begin
        match[i] = valid[i] && (((data[i] ^ key) & mask) == '0);
      end
    end

    prio_enc #(.WIDTH(DEPTH)) u_lk_enc (
      .vec   (match),
      .idx   (m_idx),
      .any   (m_any),
      .multi (m_multi)
    );

    // Register the result on a strobe and hold it until the next strobe.
    always_ff @(posedge clk) begin
      if (rst) begin
        lk_rvalid[p]                         <= 1'b0;
        lk_hit[p]                            <= 1'b0;
        lk_multi[p]                          <= 1'b0;
        lk_addr[p*ADDR_WIDTH +: ADDR_WIDTH]  <= '0;
        lk_vec[p*DEPTH +: DEPTH]             <= '0;
      end else begin
        lk_rvalid[p] <= lk_valid[p];
        if (lk_valid[p]) begin
          lk_hit[p]                           <= m_any;
          lk_multi[p]                         <= m_multi;
          lk_addr[p*ADDR_WIDTH +: ADDR_WIDTH] <= m_idx;
          lk_vec[p*DEPTH +: DEPTH]            <= match;
        end
      end
    end
  end

endmodule

// File: tb/tb_mask_alloc_cam.sv
// tb/tb_mask_alloc_cam.sv - directed scoreboard bench for mask_alloc_cam
module tb_mask_alloc_cam;
  import cam_pkg::*;

  localparam int DW = 10;
  localparam int D  = 4;
  localparam int AW = 2;
  localparam int NL = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              ins_valid;
  logic [DW-1:0]     ins_data;
  logic              ins_ready;
  logic [AW-1:0]     ins_addr;
  logic              del_valid;
  logic [AW-1:0]     del_addr;
  logic              flush;
  logic [NL-1:0]     lk_valid;
  logic [NL*DW-1:0]  lk_data;
  logic [NL*DW-1:0]  lk_mask;
  logic [NL-1:0]     lk_rvalid;
  logic [NL-1:0]     lk_hit;
  logic [NL-1:0]     lk_multi;
  logic [NL*AW-1:0]  lk_addr;
  logic [NL*D-1:0]   lk_vec;
  logic [AW:0]       count;
  logic              full;
  logic              empty;

  mask_alloc_cam #(.DATA_WIDTH(DW), .DEPTH(D), .NUM_LK(NL)) dut (
    .clk(clk), .rst(rst),
    .ins_valid(ins_valid), .ins_data(ins_data), .ins_ready(ins_ready), .ins_addr(ins_addr),
    .del_valid(del_valid), .del_addr(del_addr), .flush(flush),
    .lk_valid(lk_valid), .lk_data(lk_data), .lk_mask(lk_mask),
    .lk_rvalid(lk_rvalid), .lk_hit(lk_hit), .lk_multi(lk_multi),
    .lk_addr(lk_addr), .lk_vec(lk_vec),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         port;
    logic       hit;
    logic       multi;
    logic [1:0] addr;
    logic [3:0] vec;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_tag(input int cmd, input int proc);
    tag_t t;
    t.cmd_id  = cmd_id_t'(cmd);
    t.proc_id = proc_id_t'(proc);
    return DW'(t);
  endfunction

  task automatic lookup(input int p, input logic [DW-1:0] key, input logic [DW-1:0] mask,
                        input logic hit, input logic multi, input logic [1:0] addr,
                        input logic [3:0] vec);
    exp_t e;
    lk_valid[p]          = 1'b1;
    lk_data[p*DW +: DW]  = key;
    lk_mask[p*DW +: DW]  = mask;
    e.port = p; e.hit = hit; e.multi = multi; e.addr = addr; e.vec = vec;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    ins_valid = 1'b0;
    del_valid = 1'b0;
    flush     = 1'b0;
    lk_valid  = '0;
    for (int p = 0; p < NL; p++) begin
      if (lk_rvalid[p] === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", 32'(p + 1), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("lk_port",  32'(p),                       32'(e.port));
          chk("lk_hit",   32'(lk_hit[p]),               32'(e.hit));
          chk("lk_multi", 32'(lk_multi[p]),             32'(e.multi));
          chk("lk_addr",  32'(lk_addr[p*AW +: AW]),     32'(e.addr));
          chk("lk_vec",   32'(lk_vec[p*D +: D]),        32'(e.vec));
        end
      end
    end
    chk("lk_result_returned", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ins_valid = 1'b0; ins_data = '0; del_valid = 1'b0; del_addr = '0;
    flush = 1'b0; lk_valid = '0; lk_data = '0; lk_mask = '0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();

    // 1: reset state and an empty lookup
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_ins_ready", 32'(ins_ready), 32'd1);
    chk("reset_rvalid", 32'(lk_rvalid), 32'd0);
    lookup(0, '0, 10'h3FF, 1'b0, 1'b0, 2'd0, 4'b0000);
    tick();

    // 2: single insert and full/partial-mask lookups on both ports
    ins_valid = 1'b1; ins_data = mk_tag(1, 2);
    chk("ins_addr_first", 32'(ins_addr), 32'd0);
    tick();
    chk("count_after_ins", 32'(count), 32'd1);
    lookup(0, mk_tag(1, 2),  10'h3FF, 1'b1, 1'b0, 2'd0, 4'b0001);
    lookup(1, mk_tag(1, 3),  10'h3FC, 1'b1, 1'b0, 2'd0, 4'b0001);
    tick();
    lookup(0, mk_tag(11, 2), 10'h3FC, 1'b0, 1'b0, 2'd0, 4'b0000);
    tick();
    tick();
    chk("port1_hit_held", 32'(lk_hit[1]), 32'd1);
    chk("rvalid_single_pulse", 32'(lk_rvalid), 32'd0);

    // 3: fill from empty, then overflow insert
    flush = 1'b1;
    tick();
    chk("count_after_flush", 32'(count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      ins_valid = 1'b1; ins_data = DW'(16 * (i + 1));
      chk("ins_addr_fill", 32'(ins_addr), 32'(i));
      tick();
    end
    chk("full_after_fill", 32'(full), 32'd1);
    chk("ins_ready_full", 32'(ins_ready), 32'd0);
    chk("empty_after_fill", 32'(empty), 32'd0);
    ins_valid = 1'b1; ins_data = 10'h050;
    tick();
    chk("count_overflow", 32'(count), 32'd4);
    lookup(0, 10'h050, 10'h3FF, 1'b0, 1'b0, 2'd0, 4'b0000);
    tick();

    // 4: delete and insert together while full
    del_valid = 1'b1; del_addr = 2'd1; ins_valid = 1'b1; ins_data = 10'h055;
    tick();
    chk("count_del_while_full", 32'(count), 32'd3);
    chk("ins_ready_after_del", 32'(ins_ready), 32'd1);
    lookup(0, 10'h055, 10'h3FF, 1'b0, 1'b0, 2'd0, 4'b0000);
    ins_valid = 1'b1; ins_data = 10'h055;
    chk("ins_addr_reuse", 32'(ins_addr), 32'd1);
    tick();
    chk("count_refill", 32'(count), 32'd4);
    lookup(1, 10'h055, 10'h3FF, 1'b1, 1'b0, 2'd1, 4'b0010);
    tick();

    // 5: partial-field multi-match and delete racing a lookup
    del_valid = 1'b1; del_addr = 2'd0; tick();
    del_valid = 1'b1; del_addr = 2'd2; tick();
    chk("count_two_del", 32'(count), 32'd2);
    ins_valid = 1'b1; ins_data = 10'h105;
    chk("ins_addr_slot0", 32'(ins_addr), 32'd0);
    tick();
    ins_valid = 1'b1; ins_data = 10'h205;
    chk("ins_addr_slot2", 32'(ins_addr), 32'd2);
    tick();
    lookup(0, 10'h005, 10'h0FF, 1'b1, 1'b1, 2'd0, 4'b0101);
    tick();
    lookup(0, 10'h005, 10'h0FF, 1'b1, 1'b1, 2'd0, 4'b0101);
    del_valid = 1'b1; del_addr = 2'd0;
    tick();
    chk("count_del_lookup", 32'(count), 32'd3);
    lookup(0, 10'h005, 10'h0FF, 1'b1, 1'b0, 2'd2, 4'b0100);
    tick();

    // 6: flush beats insert, in-flight lookup sees pre-flush state
    ins_valid = 1'b1; ins_data = 10'h3FF; flush = 1'b1;
    lookup(1, '0, '0, 1'b1, 1'b1, 2'd1, 4'b1110);
    tick();
    chk("count_flush_ins", 32'(count), 32'd0);
    chk("empty_flush_ins", 32'(empty), 32'd1);
    chk("full_flush_ins", 32'(full), 32'd0);
    lookup(0, '0, '0, 1'b0, 1'b0, 2'd0, 4'b0000);
    tick();

    // Reset in the same cycle as a lookup discards it
    lk_valid[1] = 1'b1; lk_data[DW +: DW] = '0; lk_mask[DW +: DW] = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_drops_rvalid", 32'(lk_rvalid), 32'd0);
    chk("rst_clears_hit", 32'(lk_hit), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
